// File: rtl/rfdp_rd_stream.sv
// rfdp_rd_stream: burst read controller for an rfdp simple-dual-port SRAM macro.
// It accepts a (start address, word count) command and issues one read per
// cycle on the active-low macro port. A 2-entry skid FIFO absorbs the macro's
// 1-cycle read latency, and the words leave as a valid/ready stream with a
// last flag.
//
// Handshake rule for both the cmd_* and out_* channels: a transfer happens
// on a rising clk edge where valid and ready are both high. Once valid is
// high, the producer holds it and the payload stable until that transfer.
// ready may change freely and never depends on a future valid.
module rfdp_rd_stream #(
  parameter int WWORD = 256,
  parameter int DEPTH = 128,
  parameter int WADDR = $clog2(DEPTH),
  parameter int WLEN  = WADDR + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WADDR-1:0] cmd_addr,
  input  logic [WLEN-1:0]  cmd_len,
  output logic             mem_cen,
  output logic [WADDR-1:0] mem_addr,
  input  logic [WWORD-1:0] mem_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WWORD-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [WADDR-1:0] ADDR_ONE = WADDR'(1);
  localparam logic [WADDR-1:0] ADDR_MAX = WADDR'(DEPTH - 1);
  localparam logic [WLEN-1:0]  LEN_ONE  = WLEN'(1);

  state_t           state;
  state_t           state_nxt;
  logic [WADDR-1:0] rd_addr;
  logic [WLEN-1:0]  rd_left;
  logic [WLEN-1:0]  beat_left;
  logic             inflight;
  logic [WWORD-1:0] fifo_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       fifo_cnt;
  logic             accept;
  logic             issue;
  logic             pop;
  logic             push;
  logic [2:0]       occ;

  assign accept    = cmd_valid & cmd_ready;
  assign pop       = out_valid & out_ready;
  // Data returning from the macro is only meaningful after a read of ours.
  // A reset clears inflight, so stale macro output is never pushed.
  assign push      = inflight;
  // Words already committed: held in the FIFO plus one still inside the macro.
  assign occ       = {1'b0, fifo_cnt} + {2'b00, inflight};
  // A new read is allowed only if its data is guaranteed a free slot, which
  // counts the word leaving this cycle. This keeps the FIFO from overflowing.
  assign issue     = (state == S_RUN) && (rd_left != '0) &&
                     (occ < ({2'b00, pop} + 3'd2));
  assign mem_cen   = ~issue;
  assign mem_addr  = rd_addr;
  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];
  assign out_last  = out_valid & (beat_left == LEN_ONE);
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and the status outputs derived from the state.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = (cmd_len != '0) ? S_RUN : S_DRAIN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (issue && (rd_left == LEN_ONE)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if ((beat_left == '0) && !inflight) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read address and remaining-read/remaining-beat counters, loaded on command
  // acceptance, plus the flag marking a read issued in the previous cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr   <= '0;
      rd_left   <= '0;
      beat_left <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (accept) begin
        rd_addr   <= cmd_addr;
        rd_left   <= cmd_len;
        beat_left <= cmd_len;
      end else begin
        if (issue) begin
          rd_addr <= (rd_addr == ADDR_MAX) ? '0 : rd_addr + ADDR_ONE;
          rd_left <= rd_left - LEN_ONE;
        end
        if (pop) beat_left <= beat_left - LEN_ONE;
      end
    end
  end

  // Two-entry skid FIFO: the macro output is written one cycle after each read,
  // and the head entry drives the output stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= mem_q;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_rfdp_rd_stream.sv
// Bench for rfdp_rd_stream. A behavioural macro model supplies data, and a
// queue of expected words is filled from the command fields whenever a
// command is accepted.
module tb_rfdp_rd_stream;
  localparam int WWORD = 256;
  localparam int DEPTH = 128;
  localparam int WADDR = $clog2(DEPTH);
  localparam int WLEN  = WADDR + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [WADDR-1:0] cmd_addr = '0;
  logic [WLEN-1:0]  cmd_len = '0;
  logic             mem_cen;
  logic [WADDR-1:0] mem_addr;
  logic [WWORD-1:0] mem_q = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WWORD-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;

  rfdp_rd_stream #(.WWORD(WWORD), .DEPTH(DEPTH), .WADDR(WADDR), .WLEN(WLEN)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .mem_cen(mem_cen), .mem_addr(mem_addr),
    .mem_q(mem_q), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // macro model: 1-cycle read latency
  logic [WWORD-1:0] mem [DEPTH];
  always @(posedge clk) if (!mem_cen) mem_q <= mem[mem_addr];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_beats = 0;
  int n_valid = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int outstanding = 0;
  int ready_mode = 0;
  int rd_addr_log[$];
  int rd_cyc_log[$];
  int beat_cyc_log[$];
  logic [WWORD-1:0] exp_q[$];
  logic             prev_stall = 1'b0;
  logic [WWORD-1:0] prev_data = '0;
  logic             prev_last = 1'b0;

  task automatic check(input string tag, input logic [WWORD-1:0] obs, input logic [WWORD-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input int addr, input int len, output int e0);
    int n;
    n = 0;
    @(posedge clk); #1;
    cmd_addr  = WADDR'(addr);
    cmd_len   = WLEN'(len);
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("cmd_ready_seen", cmd_ready, 1);
    for (int k = 0; k < len; k++) exp_q.push_back(mem[(addr + k) % DEPTH]);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_addr  = WADDR'($urandom_range(0, DEPTH - 1));
    cmd_len   = WLEN'($urandom_range(0, 255));
    e0 = cyc - 1;
  endtask

  task automatic wait_done(input int bound);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < bound) begin @(negedge clk); #1; n++; end
    check("done_seen", done_cnt != start, 1);
    @(posedge clk); #1;
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_busy", busy, 0);
  endtask

  task automatic check_burst(input string tg, input int addr, input int len, input int e0,
                             input int rb, input int bb);
    check({tg, "_nreads"}, rd_addr_log.size() - rb, len);
    check({tg, "_nbeats"}, beat_cyc_log.size() - bb, len);
    for (int k = 0; k < len; k++) begin
      if (rb + k < rd_addr_log.size()) begin
        check({tg, "_rd_addr"}, rd_addr_log[rb + k], (addr + k) % DEPTH);
        check({tg, "_rd_cyc"}, rd_cyc_log[rb + k], e0 + 1 + k);
      end
      if (bb + k < beat_cyc_log.size()) check({tg, "_beat_cyc"}, beat_cyc_log[bb + k], e0 + 3 + k);
    end
    check({tg, "_done_cyc"}, done_cyc, e0 + len + 3);
  endtask

  task automatic wait_beats(input int target, input int bound);
    int n;
    n = 0;
    while (n_beats < target && n < bound) begin @(negedge clk); #1; n++; end
    check("beats_reached", n_beats >= target, 1);
  endtask

  initial begin
    int e0, rb, bb, nb, nv, a, l;
    logic [WWORD-1:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < WWORD / 32; j++) w[j*32 +: 32] = $urandom();
      w[7:0] = 8'(i);
      mem[i] = w;
    end

    fork
      // cycle counter
      forever begin @(posedge clk); cyc++; end
      // out_ready driver
      forever begin
        @(posedge clk); #1;
        case (ready_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'($urandom_range(0, 1));
          default: out_ready = 1'b0;
        endcase
      end
      // monitor / scoreboard
      forever begin
        @(negedge clk);
        if (rst) begin
          outstanding = 0;
          prev_stall  = 1'b0;
        end else begin
          if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, prev_data);
            check("hold_last", out_last, prev_last);
          end
          if (out_last) check("last_needs_valid", out_valid, 1);
          if (out_valid) n_valid++;
          if (!mem_cen) begin
            rd_addr_log.push_back(int'(mem_addr));
            rd_cyc_log.push_back(cyc);
            outstanding++;
          end
          if (done) begin done_cnt++; done_cyc = cyc; end
          if (out_valid && out_ready) begin
            n_beats++;
            beat_cyc_log.push_back(cyc);
            outstanding--;
            check("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              w = exp_q.pop_front();
              check("beat_data", out_data, w);
              check("beat_last", out_last, exp_q.size() == 0);
            end
          end
          if (busy) check("outstanding_le2", outstanding <= 2, 1);
          prev_stall = out_valid && !out_ready;
          prev_data  = out_data;
          prev_last  = out_last;
        end
      end
    join_none

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_mem_cen", mem_cen, 1);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // basic burst
    rb = rd_addr_log.size(); bb = beat_cyc_log.size();
    send_cmd(5, 4, e0);
    wait_done(100);
    check_burst("basic", 5, 4, e0, rb, bb);

    // address wrap
    rb = rd_addr_log.size(); bb = beat_cyc_log.size();
    send_cmd(126, 4, e0);
    wait_done(100);
    check_burst("wrap", 126, 4, e0, rb, bb);

    // long burst wrapping more than once
    rb = rd_addr_log.size(); bb = beat_cyc_log.size();
    send_cmd(100, 200, e0);
    wait_done(400);
    check_burst("long", 100, 200, e0, rb, bb);

    // zero length
    rb = rd_addr_log.size(); nb = n_beats; nv = n_valid;
    send_cmd(9, 0, e0);
    wait_done(20);
    check("zero_done_cyc", done_cyc, e0 + 1);
    check("zero_reads", rd_addr_log.size() - rb, 0);
    check("zero_beats", n_beats - nb, 0);
    check("zero_valid", n_valid - nv, 0);

    // backpressure with random ready and a 6-cycle stall
    @(negedge clk); ready_mode = 1;
    nb = n_beats;
    send_cmd(int'($urandom_range(0, DEPTH - 1)), 16, e0);
    wait_beats(nb + 3, 200);
    @(negedge clk); #1;
    ready_mode = 2;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); #1;
      if (k >= 3) check("stall_mem_cen", mem_cen, 1);
    end
    ready_mode = 1;
    wait_done(300);
    check("bp_beats", n_beats - nb, 16);
    check("bp_exp_empty", exp_q.size(), 0);

    // random bursts under random backpressure
    for (int t = 0; t < 6; t++) begin
      a = int'($urandom_range(0, DEPTH - 1));
      l = int'($urandom_range(1, 40));
      nb = n_beats;
      send_cmd(a, l, e0);
      wait_done(400);
      check("rand_beats", n_beats - nb, l);
      check("rand_exp_empty", exp_q.size(), 0);
    end

    // reset mid-burst
    @(negedge clk); ready_mode = 0;
    repeat (2) @(posedge clk);
    nb = n_beats;
    send_cmd(int'($urandom_range(0, DEPTH - 1)), 10, e0);
    wait_beats(nb + 3, 50);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("mid_rst_mem_cen", mem_cen, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_mem_addr", mem_addr, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    nb = n_beats; rb = rd_addr_log.size();
    repeat (6) @(negedge clk);
    #1;
    check("post_rst_beats", n_beats - nb, 0);
    check("post_rst_reads", rd_addr_log.size() - rb, 0);
    check("post_rst_valid", out_valid, 0);
    rb = rd_addr_log.size(); bb = beat_cyc_log.size();
    send_cmd(0, 2, e0);
    wait_done(100);
    check_burst("after_rst", 0, 2, e0, rb, bb);
    check("after_rst_exp_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard time limit
  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/rfdp_rd_stream.md
# rfdp_rd_stream

Read-side controller for the rfdp simple-dual-port SRAM macros. It accepts a burst command (start address, word count), drives the macro's active-low read enable and address, and absorbs the macro's 1-cycle read latency in a 2-entry skid FIFO. It presents the words as a valid/ready stream with a last flag. It sits between a weight/feature buffer and the downstream PE array loader, and sustains one word per cycle when the consumer never stalls.

## Interface
- `WWORD`, 256: data word width; must equal the attached macro width.
- `DEPTH`, 128: macro depth in words; the address wraps modulo `DEPTH`.
- `WADDR`, `$clog2(DEPTH)`: address width.
- `WLEN`, `WADDR+1`: burst length field width.
- `clk` in 1: single clock, shared with the macro read port.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: a burst command is offered.
- `cmd_ready` out 1: high in IDLE only.
- `cmd_addr` in `WADDR`: start word address; must be less than `DEPTH`.
- `cmd_len` in `WLEN`: number of words to read; 0 is legal.
- `mem_cen` out 1: macro read enable, active low (connects to CENA).
- `mem_addr` out `WADDR`: macro read address (connects to AA).
- `mem_q` in `WWORD`: macro read data, valid 1 cycle after `mem_cen`=0.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_data` out `WWORD`: the streamed word.
- `out_last` out 1: marks the final word of the burst.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse when the burst completes.

## Operation
- The FSM has three states: IDLE, RUN, DRAIN.
- IDLE → RUN: on `cmd_valid & cmd_ready` with `cmd_len` ≠ 0.
  - Latch the address into `rd_addr`.
  - Latch `cmd_len` into both `rd_left` and `beat_left`.
- IDLE → DRAIN: on `cmd_valid & cmd_ready` with `cmd_len` = 0. There are no reads and no beats.
- RUN: issue a read (`mem_cen`=0, `mem_addr`=`rd_addr`) when all of the following hold:
  - `rd_left` ≠ 0;
  - `fifo_cnt + inflight - pop` < 2, where `pop` = `out_valid & out_ready` and `inflight` = a read was issued last cycle.
- On each issued read:
  - `rd_addr` ← (`rd_addr`+1 == `DEPTH`) ? 0 : `rd_addr`+1;
  - `rd_left` decrements.
- RUN → DRAIN when the last read is issued (`rd_left` reaches 0).
- DRAIN → IDLE when `beat_left`=0 and `inflight`=0.
  - `done`=1 in the cycle DRAIN exits.
  - `cmd_ready` is high from the following cycle.
- FIFO:
  - Write: `mem_q` is pushed in the cycle after every issued read, unconditionally. The credit rule guarantees it never overflows.
  - Read: `out_data` comes from the head entry.
  - `out_valid` = `fifo_cnt` ≠ 0.
  - `beat_left` decrements on each pop.
  - `out_last` = `out_valid` & (`beat_left` == 1).
- While `out_valid & ~out_ready`, `out_data` and `out_last` stay stable.
- Command fields are sampled only at acceptance.
- `mem_cen`=1 whenever no read is issued. `mem_addr` is don't-care in those cycles.
- Reset values: state IDLE, `cmd_ready`=1, `mem_cen`=1, `mem_addr`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `done`=0, FIFO empty, `inflight`=0.
- Reset mid-burst:
  - All state clears immediately (asynchronous).
  - `mem_cen` returns to 1 at once.
  - Data returning from the macro after reset is discarded; a push occurs only if `inflight`=1, and `inflight` reset to 0.
- `cmd_len` greater than `DEPTH` is legal; the address wraps repeatedly.

## Timing
- The command is accepted at edge E0.
- First read cycle: `mem_cen`=0 in cycle E0+1.
- `mem_q` is captured at E0+2.
- First `out_valid` in cycle E0+3.
- With `out_ready` held high, an N-word burst gives beats in cycles E0+3 … E0+N+2, with no bubbles.
- `done` is high in cycle E0+N+3; the next command can be accepted at the end of that cycle+1.
- `cmd_len`=0: `done` is high in cycle E0+1.
- Reads issued minus words popped never exceeds 2.

## Test plan
- Reset:
  - Assert `rst` asynchronously mid-cycle → immediately `mem_cen`=1, `out_valid`=0, `busy`=0, `done`=0, `cmd_ready`=1.
- Basic burst:
  - Setup: mem[i]=i, `out_ready`=1.
  - Stimulus: `cmd_addr`=5, `cmd_len`=4.
  - Expect `mem_addr` 5,6,7,8 on consecutive cycles, then beats 5,6,7,8 starting at E0+3.
  - Expect `out_last` only on 8, `done` 1 cycle later.
- Wrap:
  - Setup: `DEPTH`=128.
  - Stimulus: `cmd_addr`=126, `cmd_len`=4.
  - Expect reads at 126,127,0,1 and data in that order, with `out_last` on word 1.
- Backpressure:
  - Stimulus: `cmd_len`=16; `out_ready` random, plus one 6-cycle stall.
  - Expect exactly 16 beats, in order, no duplicates.
  - Expect `mem_cen`=1 throughout the stall once the FIFO is full.
  - Expect outstanding reads ≤ 2 at all times, and `out_data` stable while stalled.
- Zero length:
  - Stimulus: `cmd_len`=0.
  - Expect no `mem_cen`=0, no `out_valid`, `done` at E0+1.
- Reset mid-burst:
  - Stimulus: `cmd_len`=10, `rst` pulsed after 3 beats.
  - Expect all outputs at reset values, no further beats.
  - A new command (`addr`=0, `len`=2) then yields exactly words 0,1.
